axi4_lite_regbank_slave: RTL and testbench

AXI4-lite slave-side responder: accepts write and read transactions from an AXI4-lite master and serves them from an internal bank of word-wide registers. It is the responder end of the master/slave pair on the AXI4-lite interface. It lets the object-oriented testbench and the master be exercised against a second slave with independent address/data channel ordering, byte strobes, programmable read latency and error responses.

---
 rtl/axi4_lite_regbank_slave_if.sv | 40 ++++
 rtl/axi4_lite_regbank_slave.sv | 174 +++++++++++++++++
 tb/tb_axi4_lite_regbank_slave.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_regbank_slave_if.sv
// AXI4-lite bus bundle between a master and the register-bank slave.
// Signal names follow the AXI channel naming so waveforms read naturally.
interface axi4_lite_regbank_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_lite_regbank_slave.sv
// AXI4-lite slave serving a bank of 32-bit registers. Write and read paths
// are independent state machines sharing only the register array. All bus
// outputs are registered; readies rise on the first edge after reset.
module axi4_lite_regbank_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int RD_LATENCY = 1
) (
  input logic ACLK,
  input logic ARESET,
  axi4_lite_regbank_slave_if.slave bus
);

  localparam int         IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] LAT         = 4'(RD_LATENCY);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  w_state_t              w_state;
  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [3:0]            w_strb;
  logic                  aw_ready;
  logic                  w_ready;
  logic                  b_valid;
  logic [1:0]            b_resp;

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [3:0]            wait_cnt;
  logic                  ar_ready;
  logic                  r_valid;
  logic [1:0]            r_resp;
  logic [DATA_WIDTH-1:0] r_data;

  // An address is valid only if every bit above the register index is zero.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + 2)) == '0;
  endfunction

  assign bus.AWREADY = aw_ready;
  assign bus.WREADY  = w_ready;
  assign bus.BVALID  = b_valid;
  assign bus.BRESP   = b_resp;
  assign bus.ARREADY = ar_ready;
  assign bus.RVALID  = r_valid;
  assign bus.RRESP   = r_resp;
  assign bus.RDATA   = r_data;

  // Write path: capture AW and W into one-deep buffers in any order, commit
  // with byte strobes once both are held, then hold the B response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state  <= W_IDLE;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_full && w_full) begin
            if (in_range(aw_addr)) begin
              for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) regs[aw_addr[IDX_W+1:2]][8*b +: 8] <= w_data[8*b +: 8];
              end
              b_resp <= RESP_OKAY;
            end else begin
              b_resp <= RESP_SLVERR;
            end
            b_valid <= 1'b1;
            w_state <= W_RESP;
          end else begin
            if (bus.AWVALID && aw_ready) begin
              aw_full  <= 1'b1;
              aw_addr  <= bus.AWADDR;
              aw_ready <= 1'b0;
            end else begin
              aw_ready <= !aw_full;
            end
            if (bus.WVALID && w_ready) begin
              w_full  <= 1'b1;
              w_data  <= bus.WDATA;
              w_strb  <= bus.WSTRB;
              w_ready <= 1'b0;
            end else begin
              w_ready <= !w_full;
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
            w_state  <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Read path: latch the address, spend one decode cycle plus RD_LATENCY
  // wait cycles in R_WAIT, then present the sampled register until accepted.
  // The sample uses the pre-edge register value, so a same-edge commit is
  // not visible in that response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state  <= R_IDLE;
      ar_addr  <= '0;
      wait_cnt <= '0;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= RESP_OKAY;
      r_data   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.ARVALID && ar_ready) begin
            ar_addr  <= bus.ARADDR;
            ar_ready <= 1'b0;
            wait_cnt <= LAT;
            r_state  <= R_WAIT;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_WAIT: begin
          if (wait_cnt == 4'd0) begin
            r_valid <= 1'b1;
            r_state <= R_DATA;
            if (in_range(ar_addr)) begin
              r_data <= regs[ar_addr[IDX_W+1:2]];
              r_resp <= RESP_OKAY;
            end else begin
              r_data <= '0;
              r_resp <= RESP_SLVERR;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (bus.RREADY) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
            ar_ready <= 1'b1;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_regbank_slave.sv
// Self-checking bench for axi4_lite_regbank_slave: directed scenarios then
// randomized traffic checked against an array-based register model.
module tb_axi4_lite_regbank_slave;

  localparam int RD_LAT = 1;
  localparam int NREGS  = 16;

  logic aclk;
  logic areset;
  int   checks;
  int   errors;
  logic [31:0] model [NREGS];

  axi4_lite_regbank_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_regbank_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREGS), .RD_LATENCY(RD_LAT)
  ) dut (
    .ACLK(aclk),
    .ARESET(areset),
    .bus(bus)
  );

  // Free-running clock, 10 time units per period.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Hard stop in case a scenario wedges despite its bounded waits.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic bit addr_ok(input logic [31:0] addr);
    return addr < NREGS * 4;
  endfunction

  // Full write transaction with AW and W offered together; BREADY is held
  // low for 'hold' cycles after BVALID to exercise response stability.
  task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int hold, output logic [1:0] resp);
    bit aw_done, w_done, aw_now, w_now;
    int n, lat;
    logic [1:0] resp_exp;
    resp_exp = addr_ok(addr) ? 2'b00 : 2'b10;
    bus.AWADDR = addr; bus.AWVALID = 1'b1;
    bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_now = bus.AWVALID && bus.AWREADY;
      w_now  = bus.WVALID && bus.WREADY;
      tick(); n++;
      if (aw_now) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_now)  begin w_done = 1;  bus.WVALID = 1'b0; end
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check_output("wr_accept", {31'b0, aw_done && w_done}, 32'd1);
    lat = 0;
    do begin tick(); lat++; end while (!bus.BVALID && lat < 50);
    check_output("wr_latency", lat, 32'd1);
    check_output("wr_bresp", {30'b0, bus.BRESP}, {30'b0, resp_exp});
    resp = bus.BRESP;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_output("wr_hold_bvalid", {31'b0, bus.BVALID}, 32'd1);
      check_output("wr_hold_bresp", {30'b0, bus.BRESP}, {30'b0, resp_exp});
      check_output("wr_hold_awready", {31'b0, bus.AWREADY}, 32'd0);
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check_output("wr_bvalid_clear", {31'b0, bus.BVALID}, 32'd0);
    check_output("wr_ready_back", {30'b0, bus.AWREADY, bus.WREADY}, 32'd3);
    if (addr_ok(addr)) model[addr[5:2]] = merge(model[addr[5:2]], data, strb);
  endtask

  // Full read transaction compared with the model; RREADY is held low for
  // 'hold' cycles after RVALID.
  task automatic apply_read(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp);
    bit ar_done, ar_now;
    int n, lat;
    logic [31:0] data_exp;
    logic [1:0]  resp_exp;
    data_exp = addr_ok(addr) ? model[addr[5:2]] : 32'h0;
    resp_exp = addr_ok(addr) ? 2'b00 : 2'b10;
    bus.ARADDR = addr; bus.ARVALID = 1'b1;
    ar_done = 0; n = 0;
    while (!ar_done && n < 50) begin
      ar_now = bus.ARVALID && bus.ARREADY;
      tick(); n++;
      if (ar_now) ar_done = 1;
    end
    bus.ARVALID = 1'b0;
    check_output("rd_accept", {31'b0, ar_done}, 32'd1);
    lat = 0;
    do begin tick(); lat++; end while (!bus.RVALID && lat < 50);
    check_output("rd_latency", lat, 1 + RD_LAT);
    check_output("rd_data", bus.RDATA, data_exp);
    check_output("rd_resp", {30'b0, bus.RRESP}, {30'b0, resp_exp});
    data = bus.RDATA;
    resp = bus.RRESP;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_output("rd_hold_rvalid", {31'b0, bus.RVALID}, 32'd1);
      check_output("rd_hold_rdata", bus.RDATA, data_exp);
      check_output("rd_hold_arready", {31'b0, bus.ARREADY}, 32'd0);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check_output("rd_rvalid_clear", {31'b0, bus.RVALID}, 32'd0);
    check_output("rd_rdata_zero", bus.RDATA, 32'h0);
    check_output("rd_arready_back", {31'b0, bus.ARREADY}, 32'd1);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] addr;
    checks = 0; errors = 0;
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    bus.AWADDR = '0; bus.AWVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0;
    bus.BREADY = 0; bus.ARADDR = '0; bus.ARVALID = 0; bus.RREADY = 0;
    areset = 1'b0;

    // Reset values and ready release
    #1 areset = 1'b1;
    repeat (2) tick();
    check_output("rst_readies", {29'b0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd0);
    check_output("rst_valids", {30'b0, bus.BVALID, bus.RVALID}, 32'd0);
    check_output("rst_resps", {28'b0, bus.BRESP, bus.RRESP}, 32'd0);
    check_output("rst_rdata", bus.RDATA, 32'h0);
    areset = 1'b0;
    check_output("release_readies_low", {29'b0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd0);
    tick();
    check_output("release_readies_high", {29'b0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7);

    // Write reg 3 then read it back
    apply_write(32'h0C, 32'hDEADBEEF, 4'hF, 0, resp);
    apply_read(32'h0C, 0, rdata, resp);
    check_output("reg3_value", rdata, 32'hDEADBEEF);

    // W channel three cycles ahead of AW, partial strobes
    apply_write(32'h14, 32'hAABBCCDD, 4'hF, 0, resp);
    bus.WDATA = 32'h11223344; bus.WSTRB = 4'b0101; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    check_output("wfirst_wready_low0", {31'b0, bus.WREADY}, 32'd0);
    tick();
    check_output("wfirst_wready_low1", {31'b0, bus.WREADY}, 32'd0);
    check_output("wfirst_no_bvalid", {31'b0, bus.BVALID}, 32'd0);
    tick();
    bus.AWADDR = 32'h14; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    check_output("wfirst_wready_low2", {31'b0, bus.WREADY}, 32'd0);
    tick();
    check_output("wfirst_bvalid", {31'b0, bus.BVALID}, 32'd1);
    check_output("wfirst_bresp", {30'b0, bus.BRESP}, 32'd0);
    check_output("wfirst_wready_low3", {31'b0, bus.WREADY}, 32'd0);
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check_output("wfirst_wready_back", {31'b0, bus.WREADY}, 32'd1);
    model[5] = merge(model[5], 32'h11223344, 4'b0101);
    apply_read(32'h14, 0, rdata, resp);
    check_output("wfirst_value", rdata, 32'hAA22CC44);

    // Out-of-range write and read
    apply_write(32'h40, 32'h12345678, 4'hF, 0, resp);
    check_output("oor_bresp", {30'b0, resp}, 32'd2);
    apply_read(32'h40, 0, rdata, resp);
    check_output("oor_rdata", rdata, 32'h0);
    check_output("oor_rresp", {30'b0, resp}, 32'd2);
    apply_read(32'h00, 0, rdata, resp);

    // Backpressure on both response channels
    apply_write(32'h1C, 32'hCAFEF00D, 4'hF, 5, resp);
    apply_read(32'h1C, 5, rdata, resp);

    // Read of reg 2 whose sample edge coincides with a write commit to reg 2
    apply_write(32'h08, 32'h9, 4'hF, 0, resp);
    check_output("coll_ready", {30'b0, bus.AWREADY, bus.ARREADY}, 32'd3);
    bus.ARADDR = 32'h08; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h5; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    tick();
    check_output("coll_rvalid", {31'b0, bus.RVALID}, 32'd1);
    check_output("coll_bvalid", {31'b0, bus.BVALID}, 32'd1);
    check_output("coll_old_data", bus.RDATA, 32'h9);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    model[2] = 32'h5;
    apply_read(32'h08, 0, rdata, resp);
    check_output("coll_new_data", rdata, 32'h5);

    // Reset pulsed while a read is waiting
    bus.ARADDR = 32'h0C; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    #2 areset = 1'b1;
    #1;
    check_output("midrst_outputs", {27'b0, bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID}, 32'd0);
    check_output("midrst_rdata", bus.RDATA, 32'h0);
    repeat (2) tick();
    areset = 1'b0;
    check_output("midrst_arready_low", {31'b0, bus.ARREADY}, 32'd0);
    tick();
    check_output("midrst_arready_high", {31'b0, bus.ARREADY}, 32'd1);
    check_output("midrst_rvalid", {31'b0, bus.RVALID}, 32'd0);
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    for (int i = 0; i < NREGS; i++) apply_read(32'(i * 4), 0, rdata, resp);

    // Randomized traffic: mixed reads/writes, strobes, holds, out-of-range
    for (int i = 0; i < 60; i++) begin
      addr = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        apply_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), resp);
      else
        apply_read(addr, $urandom_range(0, 3), rdata, resp);
    end
    for (int i = 0; i < NREGS; i++) apply_read(32'(i * 4), 0, rdata, resp);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
